// File: rtl/iq_to_phase_pkg.sv
// Shared constants for iq_to_phase: CORDIC arctangent table and iteration limit.
package iq_to_phase_pkg;

  localparam int MAX_ITERATIONS = 24;
  localparam int ATAN_PREC      = 32;

  // round(atan(2^-k) / (2*pi) * 2^32); one full turn is 2^32
  localparam logic [ATAN_PREC-1:0] ATAN_TABLE [MAX_ITERATIONS] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051
  };

  function automatic logic [ATAN_PREC-1:0] atan_entry(input logic [4:0] k, input int width);
    return ATAN_TABLE[k] >> (ATAN_PREC - width);
  endfunction

endpackage

// File: rtl/iq_to_phase_stage.sv
// One CORDIC vectoring micro-rotation: drives y toward zero while accumulating the angle in z.
module iq_to_phase_stage
  import iq_to_phase_pkg::*;
#(
  parameter int                     DATA_WIDTH  = 18,
  parameter int                     PHASE_WIDTH = 32,
  parameter int                     SHIFT       = 0,
  parameter logic [PHASE_WIDTH-1:0] ATAN        = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          in_valid,
  input  logic                          in_zero,
  input  logic signed [DATA_WIDTH-1:0]  in_x,
  input  logic signed [DATA_WIDTH-1:0]  in_y,
  input  logic        [PHASE_WIDTH-1:0] in_z,
  output logic                          out_valid,
  output logic                          out_zero,
  output logic signed [DATA_WIDTH-1:0]  out_x,
  output logic signed [DATA_WIDTH-1:0]  out_y,
  output logic        [PHASE_WIDTH-1:0] out_z
);

  logic signed [DATA_WIDTH-1:0] x_sh;
  logic signed [DATA_WIDTH-1:0] y_sh;

  assign x_sh = in_x >>> SHIFT;
  assign y_sh = in_y >>> SHIFT;

  // Rotate opposite to the sign of y; all updates use the previous stage's values
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_zero  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_zero  <= in_zero;
      if (!in_y[DATA_WIDTH-1]) begin
        out_x <= in_x + y_sh;
        out_y <= in_y - x_sh;
        out_z <= in_z + ATAN;
      end else begin
        out_x <= in_x - y_sh;
        out_y <= in_y + x_sh;
        out_z <= in_z - ATAN;
      end
    end
  end

endmodule

// File: rtl/iq_to_phase.sv
// Pipelined CORDIC atan2(Q,I) with AXI-Stream in/out; phase full scale = one turn.
// Optional IQ_TO_PHASE_MAG_EN adds output_magnitude_tdata (gain-included |x|).
module iq_to_phase
  import iq_to_phase_pkg::*;
#(
  parameter int INPUT_WIDTH = 16,
  parameter int PHASE_WIDTH = 32,
  parameter int ITERATIONS  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_WIDTH-1:0] input_sample_i_tdata,
  input  logic [INPUT_WIDTH-1:0] input_sample_q_tdata,
  input  logic                   input_sample_tvalid,
  output logic                   input_sample_tready,
  output logic [PHASE_WIDTH-1:0] output_phase_tdata,
  output logic                   output_phase_tvalid,
  input  logic                   output_phase_tready
`ifdef IQ_TO_PHASE_MAG_EN
  ,
  output logic [INPUT_WIDTH:0]   output_magnitude_tdata
`endif
);

  localparam int DW = INPUT_WIDTH + 2;

  logic en;
  logic signed [DW-1:0] i_ext;
  logic signed [DW-1:0] q_ext;

  logic                   pre_valid;
  logic                   pre_zero;
  logic signed [DW-1:0]   pre_x;
  logic signed [DW-1:0]   pre_y;
  logic [PHASE_WIDTH-1:0] pre_z;

  logic                   sv [0:ITERATIONS];
  logic                   szero [0:ITERATIONS];
  logic signed [DW-1:0]   sx [0:ITERATIONS];
  logic signed [DW-1:0]   sy [0:ITERATIONS];
  logic [PHASE_WIDTH-1:0] sz [0:ITERATIONS];

  // Reset term keeps tready high while rst is held, even before the first reset edge
  assign en                  = !rst || !output_phase_tvalid || output_phase_tready;
  assign input_sample_tready = en;

  assign i_ext = {{2{input_sample_i_tdata[INPUT_WIDTH-1]}}, input_sample_i_tdata};
  assign q_ext = {{2{input_sample_q_tdata[INPUT_WIDTH-1]}}, input_sample_q_tdata};

  // Fold the left half-plane onto the right one so the CORDIC range (+/-99 deg) suffices
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_valid <= 1'b0;
      pre_zero  <= 1'b0;
      pre_x     <= '0;
      pre_y     <= '0;
      pre_z     <= '0;
    end else if (en) begin
      pre_valid <= input_sample_tvalid;
      pre_zero  <= (i_ext == '0) && (q_ext == '0);
      if (i_ext[DW-1]) begin
        pre_x <= -i_ext;
        pre_y <= -q_ext;
        pre_z <= {1'b1, {(PHASE_WIDTH-1){1'b0}}};
      end else begin
        pre_x <= i_ext;
        pre_y <= q_ext;
        pre_z <= '0;
      end
    end
  end

  assign sv[0]    = pre_valid;
  assign szero[0] = pre_zero;
  assign sx[0]    = pre_x;
  assign sy[0]    = pre_y;
  assign sz[0]    = pre_z;

  for (genvar k = 0; k < ITERATIONS; k++) begin : g_stage
    localparam logic [PHASE_WIDTH-1:0] ATAN_K = PHASE_WIDTH'(atan_entry(5'(k), PHASE_WIDTH));
    iq_to_phase_stage #(
      .DATA_WIDTH (DW),
      .PHASE_WIDTH(PHASE_WIDTH),
      .SHIFT      (k),
      .ATAN       (ATAN_K)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .in_valid (sv[k]),
      .in_zero  (szero[k]),
      .in_x     (sx[k]),
      .in_y     (sy[k]),
      .in_z     (sz[k]),
      .out_valid(sv[k+1]),
      .out_zero (szero[k+1]),
      .out_x    (sx[k+1]),
      .out_y    (sy[k+1]),
      .out_z    (sz[k+1])
    );
  end

`ifdef IQ_TO_PHASE_MAG_EN
  logic signed [DW-1:0] x_abs;
  assign x_abs = sx[ITERATIONS][DW-1] ? -sx[ITERATIONS] : sx[ITERATIONS];
`endif

  // Output register; data only loads with a valid sample so it holds across bubbles
  always_ff @(posedge clk) begin
    if (!rst) begin
      output_phase_tvalid    <= 1'b0;
      output_phase_tdata     <= '0;
`ifdef IQ_TO_PHASE_MAG_EN
      output_magnitude_tdata <= '0;
`endif
    end else if (en) begin
      output_phase_tvalid <= sv[ITERATIONS];
      if (sv[ITERATIONS]) begin
        output_phase_tdata     <= szero[ITERATIONS] ? '0 : sz[ITERATIONS];
`ifdef IQ_TO_PHASE_MAG_EN
        output_magnitude_tdata <= szero[ITERATIONS] ? '0 : (INPUT_WIDTH+1)'(x_abs);
`endif
      end
    end
  end

endmodule

// File: tb/tb_iq_to_phase.sv
// Directed self-checking bench for iq_to_phase (default parameters).
module tb_iq_to_phase;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in_i = 16'd0;
  logic [15:0] in_q = 16'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
`ifdef IQ_TO_PHASE_MAG_EN
  logic [16:0] out_mag;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int si [64];
  int sq [64];

  always #5 clk = ~clk;

  iq_to_phase dut (
    .clk                 (clk),
    .rst                 (rst),
    .input_sample_i_tdata(in_i),
    .input_sample_q_tdata(in_q),
    .input_sample_tvalid (in_valid),
    .input_sample_tready (in_ready),
    .output_phase_tdata  (out_data),
    .output_phase_tvalid (out_valid),
    .output_phase_tready (out_ready)
`ifdef IQ_TO_PHASE_MAG_EN
    ,
    .output_magnitude_tdata(out_mag)
`endif
  );

  task automatic check(input string tag, input bit ok, input longint obs, input longint exp);
    n_cmp++;
    assert (ok === 1'b1) else begin
      n_mis++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit near(input logic [31:0] a, input logic [31:0] b, input int tol);
    int d;
    d = int'(a - b);
    return (d <= tol) && (d >= -tol);
  endfunction

  function automatic bit is_stall(input int cyc);
    return cyc inside {20, 21, 25, 33, 34, 40, 48, 55, 56, 70};
  endfunction

  task automatic run_one(input string tag, input int i, input int q, input logic [31:0] exp_ph,
                         input int exp_mag, input bit chk_mag);
    int lat;
    in_i = 16'(i);
    in_q = 16'(q);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "_ready"}, in_ready === 1'b1, longint'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat == 18, lat, 18);
    check({tag, "_phase"}, near(out_data, exp_ph, 1 << 18), longint'(out_data), longint'(exp_ph));
`ifdef IQ_TO_PHASE_MAG_EN
    if (chk_mag)
      check({tag, "_mag"}, near(32'(out_mag), 32'(exp_mag), 16), longint'(out_mag), exp_mag);
`else
    if (chk_mag && exp_mag < 0) $display("unexpected magnitude request for %s", tag);
`endif
    @(posedge clk); #1;
  endtask

  task automatic stream(input string tag, input bit use_stall);
    int sent, got, first_in, first_out;
    bit held;
    logic [31:0] held_data;
    logic [31:0] exp_ph;
    sent = 0; got = 0; first_in = -1; first_out = -1; held = 1'b0; held_data = 32'd0;
    for (int cyc = 0; cyc < 600 && got < 64; cyc++) begin
      in_valid = (sent < 64);
      in_i = (sent < 64) ? 16'(si[sent]) : 16'd0;
      in_q = (sent < 64) ? 16'(sq[sent]) : 16'd0;
      out_ready = !(use_stall && is_stall(cyc));
      #1;
      if (first_out < 0 && out_valid === 1'b1) first_out = cyc;
      if (held)
        check({tag, "_hold"}, out_valid === 1'b1 && out_data === held_data,
              longint'(out_data), longint'(held_data));
      check({tag, "_tready"}, in_ready === (!out_valid || out_ready),
            longint'(in_ready), longint'(!out_valid || out_ready));
      held = out_valid && !out_ready;
      held_data = out_data;
      if (out_valid && out_ready) begin
        exp_ph = 32'(got) << 24;
        check({tag, "_phase"}, near(out_data, exp_ph, 1 << 18), longint'(out_data), longint'(exp_ph));
        got++;
      end
      if (in_valid && in_ready) begin
        if (first_in < 0) first_in = cyc;
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check({tag, "_count"}, got == 64, got, 64);
    if (!use_stall)
      check({tag, "_latency"}, (first_out - first_in) == 18, first_out - first_in, 18);
  endtask

  initial begin
    bit seen;
    for (int n = 0; n < 64; n++) begin
      si[n] = int'(16384.0 * $cos(2.0 * 3.141592653589793 * n / 256.0));
      sq[n] = int'(16384.0 * $sin(2.0 * 3.141592653589793 * n / 256.0));
    end

    // reset state
    rst = 1'b0;
    #1;
    check("reset_tready_before_edge", in_ready === 1'b1, longint'(in_ready), 1);
    @(posedge clk); @(posedge clk); #1;
    check("reset_tvalid", out_valid === 1'b0, longint'(out_valid), 0);
    check("reset_tdata", out_data === 32'd0, longint'(out_data), 0);
    check("reset_tready", in_ready === 1'b1, longint'(in_ready), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_reset_tready", in_ready === 1'b1, longint'(in_ready), 1);

    // axis and boundary vectors
    run_one("pos_i",   16384,      0, 32'h00000000, 26981, 1'b0);
    run_one("pos_q",       0,  16384, 32'h40000000, 26981, 1'b0);
    run_one("neg_i",  -16384,      0, 32'h80000000, 26981, 1'b0);
    run_one("neg_q",       0, -16384, 32'hC0000000, 26981, 1'b0);
    run_one("zero",        0,      0, 32'h00000000,     0, 1'b1);
    check("zero_exact", out_data === 32'd0, longint'(out_data), 0);
    run_one("min_i",  -32768,      0, 32'h80000000, 53961, 1'b0);
    run_one("min_iq", -32768, -32768, 32'hA0000000, 76312, 1'b0);
    run_one("oct1",    12000,  16000, 32'h25C80A3B, 32935, 1'b1);

    // back-to-back rotating vector, then the same stream with output stalls
    stream("stream", 1'b0);
    stream("stall", 1'b1);

    // reset with 8 samples in flight
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      in_i = 16'(si[n + 8]);
      in_q = 16'(sq[n + 8]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("flush_tvalid", out_valid === 1'b0, longint'(out_valid), 0);
    check("flush_tdata", out_data === 32'd0, longint'(out_data), 0);
    check("flush_tready", in_ready === 1'b1, longint'(in_ready), 1);
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check("flush_no_emit", seen == 1'b0, longint'(seen), 0);
    run_one("after_flush", 0, 16384, 32'h40000000, 26981, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
